// File: rtl/dly_seq_pkg.sv
// Shared encodings and constant helpers for the GearBox delay-control sequencer.
package dly_seq_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_PULSE   = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_ADJ_INC = 2'b10;
    localparam logic [1:0] OP_ADJ_DEC = 2'b11;

    function automatic int popcount(input logic [31:0] loc);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (loc[i]) n++;
        end
        return n;
    endfunction

    // Index of the k-th set bit of loc, LSB first; 0 when loc has fewer bits set.
    function automatic int site_addr(input logic [31:0] loc, input int k);
        int n;
        int res;
        n   = 0;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if (loc[i]) begin
                if (n == k) res = i;
                n++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dly_cmd_sequencer_arb.sv
// Round-robin picker: first set request at or after i_ptr, wrapping; purely combinational.
module dly_rr_arbiter #(
    parameter int NUM_DLY = 20,
    parameter int IDX_W   = (NUM_DLY > 1) ? $clog2(NUM_DLY) : 1
) (
    input  logic [NUM_DLY-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_DLY-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        int k;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        k     = 0;
        for (int off = 0; off < NUM_DLY; off++) begin
            k = (int'(i_ptr) + off) % NUM_DLY;
            if (!o_any && i_req[k]) begin
                o_any    = 1'b1;
                o_idx    = IDX_W'(k);
                o_gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dly_cmd_sequencer.sv
// Shares the GearBox delay-control port among NUM_DLY requesters, one operation at a time.
// Optional DLY_SEQ_ERR_EN: acks unmapped requesters immediately and flags err_unmapped.
module dly_cmd_sequencer
    import dly_seq_pkg::*;
#(
    parameter int                      NUM_DLY       = 20,
    parameter int                      NUM_GB_SITES  = 20,
    parameter logic [NUM_GB_SITES-1:0] DLY_LOC       = 20'h0C117,
    parameter int                      ADDR_WIDTH    = 5,
    parameter int                      DLY_TAP_WIDTH = 6,
    parameter int                      SETUP_CYC     = 1,
    parameter int                      SETTLE_CYC    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_DLY-1:0]               req,
    input  logic [2*NUM_DLY-1:0]             req_op,
    output logic [NUM_DLY-1:0]               ack,
    output logic                             busy,
    output logic [NUM_DLY*DLY_TAP_WIDTH-1:0] tap_out,
    output logic [ADDR_WIDTH-1:0]            f2g_dly_addr,
    output logic                             cntrl_dly_ld,
    output logic                             cntrl_dly_adj,
    output logic                             cntrl_dly_incdec,
`ifdef DLY_SEQ_ERR_EN
    output logic                             err_unmapped,
`endif
    input  logic [DLY_TAP_WIDTH-1:0]         g2f_dly_tap_value
);

    localparam int IDX_W     = (NUM_DLY > 1) ? $clog2(NUM_DLY) : 1;
    localparam int LOC_BITS  = popcount(32'(DLY_LOC));
    localparam int NUM_VALID = (LOC_BITS < NUM_DLY) ? LOC_BITS : NUM_DLY;

    logic [2:0]                       r_state;
    logic [7:0]                       r_cnt;
    logic [IDX_W-1:0]                 r_g;
    logic [NUM_DLY-1:0]               r_gnt;
    logic [1:0]                       r_op;
    logic [IDX_W-1:0]                 r_ptr;
    logic [ADDR_WIDTH-1:0]            r_addr;
    logic [NUM_DLY*DLY_TAP_WIDTH-1:0] r_tap;

    logic [NUM_DLY-1:0]    w_valid;
    logic [ADDR_WIDTH-1:0] w_site_tbl [NUM_DLY];
    logic [NUM_DLY-1:0]    w_req_v;
    logic [NUM_DLY-1:0]    w_gnt;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_any;
    logic [NUM_DLY-1:0]    w_ack_cap;

    for (genvar k = 0; k < NUM_DLY; k++) begin : g_site
        assign w_valid[k]    = (k < NUM_VALID);
        assign w_site_tbl[k] = ADDR_WIDTH'(site_addr(32'(DLY_LOC), k));
    end

    assign w_req_v = req & w_valid;

    dly_rr_arbiter #(
        .NUM_DLY (NUM_DLY),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req (w_req_v),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_g     <= '0;
            r_gnt   <= '0;
            r_op    <= OP_READ;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_tap   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_g     <= w_idx;
                        r_gnt   <= w_gnt;
                        r_op    <= req_op[int'(w_idx)*2 +: 2];
                        r_addr  <= w_site_tbl[w_idx];
                        r_cnt   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == 8'(SETUP_CYC - 1)) begin
                        r_cnt   <= '0;
                        // Reads have nothing to strobe; go straight to settle/capture.
                        r_state <= (r_op == OP_READ) ? S_SETTLE : S_PULSE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_PULSE: begin
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == 8'(SETTLE_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_CAPTURE: begin
                    r_tap[int'(r_g)*DLY_TAP_WIDTH +: DLY_TAP_WIDTH] <= g2f_dly_tap_value;
                    r_ptr   <= (r_g == IDX_W'(NUM_VALID - 1)) ? '0 : r_g + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_ack_cap        = (r_state == S_CAPTURE) ? r_gnt : '0;
    assign busy             = (r_state != S_IDLE);
    assign f2g_dly_addr     = r_addr;
    assign tap_out          = r_tap;
    assign cntrl_dly_ld     = (r_state == S_PULSE) && (r_op == OP_LOAD);
    assign cntrl_dly_adj    = (r_state == S_PULSE) && r_op[1];
    assign cntrl_dly_incdec = (r_state == S_PULSE) && (r_op == OP_ADJ_INC);

`ifdef DLY_SEQ_ERR_EN
    logic [NUM_DLY-1:0] w_req_inv;
    logic [NUM_DLY-1:0] r_err_ack;
    logic               r_err;

    assign w_req_inv = req & ~w_valid;

    // Unmapped requests are only serviced when no mapped request competes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_ack <= '0;
            r_err     <= 1'b0;
        end else if ((r_state == S_IDLE) && !w_any && (|w_req_inv)) begin
            r_err_ack <= w_req_inv & (~w_req_inv + 1'b1);
            r_err     <= 1'b1;
        end else begin
            r_err_ack <= '0;
        end
    end

    assign err_unmapped = r_err;
    assign ack          = w_ack_cap | r_err_ack;
`else
    assign ack          = w_ack_cap;
`endif

endmodule

// File: tb/tb_dly_cmd_sequencer.sv
// Randomized bench: transaction-timeline reference model checked every cycle against the sequencer.
module tb_dly_cmd_sequencer;

    localparam int NUM    = 20;
    localparam int TW     = 6;
    localparam int NVALID = 7;
    localparam int NCYC   = 4000;

    logic                clk;
    logic                rst;
    logic [NUM-1:0]      req;
    logic [2*NUM-1:0]    req_op;
    logic [NUM-1:0]      ack;
    logic                busy;
    logic [NUM*TW-1:0]   tap_out;
    logic [4:0]          f2g_dly_addr;
    logic                cntrl_dly_ld;
    logic                cntrl_dly_adj;
    logic                cntrl_dly_incdec;
    logic [TW-1:0]       g2f_dly_tap_value;
`ifdef DLY_SEQ_ERR_EN
    logic                err_unmapped;
`endif

    dly_cmd_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .req_op            (req_op),
        .ack               (ack),
        .busy              (busy),
        .tap_out           (tap_out),
        .f2g_dly_addr      (f2g_dly_addr),
        .cntrl_dly_ld      (cntrl_dly_ld),
        .cntrl_dly_adj     (cntrl_dly_adj),
        .cntrl_dly_incdec  (cntrl_dly_incdec),
`ifdef DLY_SEQ_ERR_EN
        .err_unmapped      (err_unmapped),
`endif
        .g2f_dly_tap_value (g2f_dly_tap_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    endtask

    // Reference model: an operation is a timeline counted from its grant cycle.
    // Offset 1 = address setup, 2 = strobe (writes only), last offset = capture + ack.
    int          site_of [NVALID] = '{0, 1, 2, 4, 8, 14, 15};
    bit          m_act;
    int          m_t, m_len, m_g, m_ptr, m_addr;
    logic [1:0]  m_op;
    logic [TW-1:0] m_tap [NUM];
    logic [NUM-1:0] m_eack;
    bit          m_err;

    task automatic model_step();
        int found;
        if (!rst) begin
            m_act = 0; m_t = 0; m_len = 0; m_g = 0; m_ptr = 0; m_addr = 0; m_op = 2'b00;
            m_eack = '0; m_err = 0;
            for (int k = 0; k < NUM; k++) m_tap[k] = '0;
            return;
        end
        m_eack = '0;
        if (m_act) begin
            if (m_t == m_len) begin
                m_tap[m_g] = g2f_dly_tap_value;
                m_ptr = (m_g + 1) % NVALID;
                m_act = 0;
            end else begin
                m_t++;
            end
        end else begin
            found = -1;
            for (int off = 0; off < NVALID; off++)
                if (found < 0 && req[(m_ptr + off) % NVALID]) found = (m_ptr + off) % NVALID;
            if (found >= 0) begin
                m_act  = 1;
                m_g    = found;
                m_op   = req_op[2*found +: 2];
                m_len  = (m_op == 2'b00) ? 4 : 5;
                m_t    = 1;
                m_addr = site_of[found];
            end
`ifdef DLY_SEQ_ERR_EN
            else begin
                for (int k = NUM - 1; k >= NVALID; k--)
                    if (req[k]) m_eack = NUM'(1) << k;
                if (m_eack != '0) m_err = 1;
            end
`endif
        end
    endtask

    logic [NUM-1:0]    e_ack;
    logic [NUM*TW-1:0] e_tap;
    bit                e_stb;

    initial begin
        rst = 1'b0;
        req = '0;
        req_op = '0;
        g2f_dly_tap_value = '0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);

            e_ack = '0;
            if (m_act && m_t == m_len) e_ack[m_g] = 1'b1;
            e_ack |= m_eack;
            e_stb = m_act && (m_t == 2) && (m_op != 2'b00);
            for (int k = 0; k < NUM; k++) e_tap[k*TW +: TW] = m_tap[k];

            chk("ack", 128'(ack), 128'(e_ack));
            chk("busy", 128'(busy), 128'(m_act));
            chk("addr", 128'(f2g_dly_addr), 128'(m_addr));
            chk("ld", 128'(cntrl_dly_ld), 128'(e_stb && m_op == 2'b01));
            chk("adj", 128'(cntrl_dly_adj), 128'(e_stb && m_op[1]));
            chk("incdec", 128'(cntrl_dly_incdec), 128'(e_stb && m_op == 2'b10));
            chk("tap_out", 128'(tap_out), 128'(e_tap));
`ifdef DLY_SEQ_ERR_EN
            chk("err_unmapped", 128'(err_unmapped), 128'(m_err));
`endif

            // Next-cycle stimulus; requests drop in their ack cycle, so no re-request.
            rst = !(cyc < 2 || $urandom_range(0, 199) == 0);
            g2f_dly_tap_value = TW'($urandom);
            for (int k = 0; k < 10; k++) begin
                if (e_ack[k]) begin
                    req[k] = 1'b0;
                end else if (!req[k]) begin
                    if ($urandom_range(0, (k < NVALID) ? 11 : 40) == 0) begin
                        req[k] = 1'b1;
                        req_op[2*k +: 2] = 2'($urandom);
                    end
                end else if (k >= NVALID && $urandom_range(0, 7) == 0) begin
                    req[k] = 1'b0;
                end
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dly_cmd_sequencer.md
Name: dly_cmd_sequencer

Overview:
- Shares the single GearBox delay-control port among NUM_DLY user requesters. That port is the f2g_dly_addr bus, the ld/adj/incdec strobes and the muxed 6-bit tap return.
- Arbitrates requests round-robin, then sequences address setup, the control strobe, settle time and tap capture for one delay at a time.
- Returns a per-requester ack and a latched tap value.
- Sits between user fabric logic and the delay address/control path to the GearBox.

Parameters:
- NUM_DLY, 20, number of requester slots (1..20).
- NUM_GB_SITES, 20, number of GearBox delay sites.
- DLY_LOC, 20'h0C117, site-occupancy mask; requester k maps to the site index of the k-th set bit (LSB first).
- ADDR_WIDTH, 5, width of f2g_dly_addr.
- DLY_TAP_WIDTH, 6, width of the tap value returned from the GearBox.
- SETUP_CYC, 1, cycles the address is held stable before the strobe (>=1).
- SETTLE_CYC, 2, cycles after the strobe before tap capture (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- req  in  NUM_DLY  per-requester command request; level, held until ack.
- req_op  in  2*NUM_DLY  per-requester op, slot k = [2k+1:2k]: 00 read, 01 load, 10 adjust-inc, 11 adjust-dec.
- ack  out  NUM_DLY  one-cycle completion pulse, one-hot.
- busy  out  1  high whenever state != IDLE.
- tap_out  out  NUM_DLY*DLY_TAP_WIDTH  last captured tap per requester.
- f2g_dly_addr  out  ADDR_WIDTH  GearBox delay-site address.
- cntrl_dly_ld  out  1  load strobe.
- cntrl_dly_adj  out  1  adjust strobe.
- cntrl_dly_incdec  out  1  direction; 1 = increment.
- g2f_dly_tap_value  in  DLY_TAP_WIDTH  muxed tap value from the GearBox.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Cleared: state IDLE, rr_ptr 0, ack 0, busy 0, f2g_dly_addr 0, all strobes 0, tap_out all 0.
  - Reset mid-operation aborts the operation: no strobe and no ack the next cycle, and tap_out is cleared.
- Valid mask:
  - requester k is valid iff k < popcount(DLY_LOC).
  - Requests from invalid requesters are masked (see Optional Feature).
- FSM: IDLE -> SETUP -> PULSE -> SETTLE -> CAPTURE -> IDLE.
  - IDLE, at least one valid req: grant the first valid req at or after rr_ptr, wrapping. Latch grant index g, req_op[g] and site_addr(g). Next state SETUP.
  - SETUP: f2g_dly_addr = site_addr(g); strobes 0; lasts SETUP_CYC cycles.
    - If op = read, go straight to SETTLE and skip PULSE.
  - PULSE: exactly 1 cycle.
    - load: cntrl_dly_ld=1.
    - adjust: cntrl_dly_adj=1 and cntrl_dly_incdec = ~op[0].
    - Address stays held.
  - SETTLE: strobes 0, address held, SETTLE_CYC cycles.
  - CAPTURE: 1 cycle.
    - tap_out slot g <= g2f_dly_tap_value.
    - ack[g]=1.
    - rr_ptr <= (g+1) mod popcount(DLY_LOC).
  - Outside PULSE, cntrl_dly_incdec = 0.
- Latency, with req first seen in IDLE at cycle 0 and defaults:
  - load/adjust: address valid cycles 1–4, strobe cycle 2, ack cycle 5.
  - read: ack cycle 4.
  - Back-to-back: the next grant is evaluated in the IDLE cycle after CAPTURE, so throughput is one op per 6 cycles (5 for reads).
- Request and op handling:
  - req and req_op are sampled only in IDLE.
  - Deasserting req mid-operation does not abort it; ack still fires.
  - req still high in the cycle after ack is treated as a new request.
- f2g_dly_addr holds its last value in IDLE and is only updated at grant.
- tap_out slots hold their values until the next capture for that slot or a reset.

Optional Feature:
- Macro: DLY_SEQ_ERR_EN.
- Defined:
  - Adds output err_unmapped (1 bit), sticky, cleared only by reset.
  - A request from an invalid requester receives ack the cycle after it is seen in IDLE, with no bus activity and no tap_out update, and sets err_unmapped.
  - Valid requests keep priority.
- Undefined: invalid requests are never granted and never acked; there is no error port.

Decomposition:
- Package dly_seq_pkg:
  - state encoding: IDLE, SETUP, PULSE, SETTLE, CAPTURE;
  - op codes: OP_READ, OP_LOAD, OP_ADJ_INC, OP_ADJ_DEC;
  - function site_addr(loc, k), which returns the index of the k-th set bit;
  - function popcount(loc).
- One sub-module, dly_rr_arbiter:
  - parameterised NUM_DLY;
  - inputs: masked req vector, rr_ptr;
  - outputs: one-hot grant, binary index, any_grant.

Test Plan:
Each scenario uses DLY_LOC=20'h0C117 (sites 0,1,2,4,8,14,15, so 7 valid requesters).
1. Load: req[3]=1, op=01 -> f2g_dly_addr=4 from cycle 1; cntrl_dly_ld=1 only in cycle 2; tap=6'h2A driven -> ack[3] in cycle 5; tap_out[23:18]=6'h2A.
2. Adjust-dec: req[5], op=11 -> addr=14; adj=1 and incdec=0 in cycle 2; ack[5] in cycle 5. Repeat with op=10 -> incdec=1 in the pulse cycle.
3. Round-robin: req[0] and req[2] held high continuously -> acks alternate 0, 2, 0, 2 with 6-cycle spacing; no requester starves.
4. Reset mid-operation: rst=0 during PULSE -> next cycle all strobes 0, busy 0, tap_out 0, no ack; a fresh req[1] then completes normally at addr 1.
5. Invalid requester: req[9]=1 -> without the macro: never acked, busy stays 0. With DLY_SEQ_ERR_EN: ack[9] in cycle 1 and err_unmapped=1, sticky until reset.
6. Read: req[6], op=00 -> addr=15; no strobe at any time; ack in cycle 4; tap_out slot 6 updated.
